rr_arbiter_merge: RTL and testbench

- Clocked N-input arbitrating merge for the spike/packet network of the SNN accelerator.
- Each cycle it selects one requesting input by a programmable policy: round-robin, fixed priority or pseudo-random.
- It pushes the winner's data and source index into a small output FIFO.
- It generalises the two-input arbiter plus winner-index channel to NUM_IN inputs, parametrised width, buffered output and selectable fairness.

---
 rtl/rr_arbiter_merge_pkg.sv | 34 +++
 rtl/rr_arbiter_merge_if.sv | 24 ++
 rtl/rr_arbiter_merge_fifo.sv | 51 +++++
 rtl/rr_arbiter_merge.sv | 75 +++++++
 tb/tb_rr_arbiter_merge.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_merge_pkg.sv
// Shared types and helpers for the SNN network-on-chip arbitration blocks.
package snn_noc_pkg;

   typedef enum logic [1:0] {
      ARB_RR    = 2'd0,
      ARB_FIXED = 2'd1,
      ARB_RAND  = 2'd2
   } arb_mode_e;

   // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [15:0] LFSR_POLY = 16'hB400;
   localparam int          MAX_IN    = 16;

   // Index of the first set bit of req[n-1:0], searching upward from start with wrap-around.
   function automatic logic [3:0] rot_first_one(input logic [MAX_IN-1:0] req,
                                                 input logic [3:0]        start,
                                                 input int                n);
      logic [3:0] res;
      logic       found;
      int         s;
      res   = start;
      found = 1'b0;
      for (int k = 0; k < MAX_IN; k++) begin
         s = int'(start) + k;
         if (s >= n) s = s - n;
         if ((k < n) && !found && req[4'(s)]) begin
            res   = 4'(s);
            found = 1'b1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter_merge_if.sv
// Request side and output side of the arbitrating merge, grouped as one bundle.
interface rr_arbiter_merge_if #(
   parameter int NUM_IN    = 4,
   parameter int WIDTH     = 12,
   parameter int OUT_DEPTH = 2
);
   localparam int IDX_W = $clog2(NUM_IN);
   localparam int OCC_W = $clog2(OUT_DEPTH + 1);

   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_ready;
   logic                    out_valid;
   logic [WIDTH-1:0]        out_data;
   logic [IDX_W-1:0]        out_src;
   logic                    out_ready;
   logic [OCC_W-1:0]        occupancy;

   modport master (output in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data, out_src, occupancy);

   modport slave  (input  in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data, out_src, occupancy);
endinterface

// File: rtl/rr_arbiter_merge_fifo.sv
// Small output FIFO; depth need not be a power of two. Pushes are only issued when a slot exists.
module arb_fifo #(
   parameter  int W     = 16,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     wrData,
   output logic [W-1:0]     rdData,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wrPtr, rdPtr;
   logic             doPush, doPop;

   function automatic logic [PTR_W-1:0] incPtr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty  = (count == '0);
   assign full   = (count == CNT_W'(DEPTH));
   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);
   assign rdData = mem[rdPtr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (doPush) begin
            mem[wrPtr] <= wrData;
            wrPtr      <= incPtr(wrPtr);
         end
         if (doPop) rdPtr <= incPtr(rdPtr);
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/rr_arbiter_merge.sv
// N-input arbitrating merge: combinational grant by policy, winner and its index buffered in arb_fifo.
module rr_arbiter_merge
   import snn_noc_pkg::*;
#(
   parameter  int          NUM_IN    = 4,
   parameter  int          WIDTH     = 12,
   parameter  int          OUT_DEPTH = 2,
   parameter  int          MODE      = 0,
   parameter  logic [15:0] LFSR_SEED = 16'hACE1,
   localparam int          IDX_W     = $clog2(NUM_IN)
) (
   input  logic             clk,
   input  logic             rst_n,
   rr_arbiter_merge_if.slave bus
);
   localparam arb_mode_e POLICY = arb_mode_e'(MODE);

   logic [IDX_W-1:0]       ptr, start, grantIdx, lfsrIdx;
   logic [15:0]            lfsr;
   logic                   space, grant, fifoFull, fifoEmpty;
   logic [WIDTH-1:0]       winData;
   logic [IDX_W+WIDTH-1:0] headWord;

   assign lfsrIdx = lfsr[IDX_W-1:0];

   always_comb begin
      start = '0;
      case (POLICY)
         ARB_RR:   start = ptr;
         ARB_RAND: start = (int'(lfsrIdx) >= NUM_IN) ? lfsrIdx - IDX_W'(NUM_IN) : lfsrIdx;
         default:  start = '0;
      endcase
   end

   // A simultaneous pop frees the slot this cycle's winner will occupy.
   assign space    = !fifoFull || (bus.out_valid && bus.out_ready);
   assign grant    = rst_n && space && (|bus.in_valid);
   assign grantIdx = IDX_W'(rot_first_one(16'(bus.in_valid), 4'(start), NUM_IN));
   assign bus.in_ready = grant ? (NUM_IN'(1) << grantIdx) : '0;

   always_comb begin
      winData = '0;
      for (int i = 0; i < NUM_IN; i++)
         if (grantIdx == IDX_W'(i)) winData = bus.in_data[i*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr  <= '0;
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_POLY : 16'h0000);
         if (grant && (POLICY == ARB_RR))
            ptr <= (grantIdx == IDX_W'(NUM_IN - 1)) ? '0 : grantIdx + 1'b1;
      end
   end

   arb_fifo #(
      .W     (IDX_W + WIDTH),
      .DEPTH (OUT_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (grant),
      .pop    (bus.out_ready),
      .wrData ({grantIdx, winData}),
      .rdData (headWord),
      .full   (fifoFull),
      .empty  (fifoEmpty),
      .count  (bus.occupancy)
   );

   assign bus.out_valid = !fifoEmpty;
   assign {bus.out_src, bus.out_data} = headWord;
endmodule

// File: tb/tb_rr_arbiter_merge.sv
// Directed bench for rr_arbiter_merge: one instance per arbitration policy sharing clock and reset.
module tb_rr_arbiter_merge;
   logic clk = 1'b0;
   logic rst_n;
   int   nCheck = 0;
   int   nPass  = 0;

   always #5 clk = ~clk;

   rr_arbiter_merge_if #(.NUM_IN(4), .WIDTH(12), .OUT_DEPTH(2)) rrIf ();
   rr_arbiter_merge_if #(.NUM_IN(4), .WIDTH(12), .OUT_DEPTH(2)) fxIf ();
   rr_arbiter_merge_if #(.NUM_IN(4), .WIDTH(12), .OUT_DEPTH(2)) rdIf ();

   rr_arbiter_merge #(.NUM_IN(4), .WIDTH(12), .OUT_DEPTH(2), .MODE(0), .LFSR_SEED(16'hACE1))
      dutRr (.clk(clk), .rst_n(rst_n), .bus(rrIf));
   rr_arbiter_merge #(.NUM_IN(4), .WIDTH(12), .OUT_DEPTH(2), .MODE(1), .LFSR_SEED(16'hACE1))
      dutFx (.clk(clk), .rst_n(rst_n), .bus(fxIf));
   rr_arbiter_merge #(.NUM_IN(4), .WIDTH(12), .OUT_DEPTH(2), .MODE(2), .LFSR_SEED(16'hACE1))
      dutRd (.clk(clk), .rst_n(rst_n), .bus(rdIf));

   function automatic logic [47:0] dataSet(input logic [11:0] base);
      return {base + 12'd3, base + 12'd2, base + 12'd1, base};
   endfunction

   task automatic nextCyc;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rrIf.in_valid = 4'b1111; rrIf.in_data = dataSet(12'h100); rrIf.out_ready = 1'b0;
      fxIf.in_valid = 4'b1111; fxIf.in_data = dataSet(12'h100); fxIf.out_ready = 1'b0;
      nextCyc;
      nextCyc;
      nCheck++; if (rrIf.occupancy !== 2'd2) $display("FAIL pre_reset_occ: got %0d want 2", rrIf.occupancy); else nPass++;
      rst_n = 1'b0;
      #1;
      nCheck++; if (rrIf.occupancy !== 2'd0 || rrIf.out_valid !== 1'b0)
         $display("FAIL async_reset: occ %0d valid %b want 0 0", rrIf.occupancy, rrIf.out_valid); else nPass++;
      nCheck++; if (rrIf.out_data !== 12'h000 || rrIf.out_src !== 2'd0)
         $display("FAIL reset_head: data %h src %0d want 000 0", rrIf.out_data, rrIf.out_src); else nPass++;
      for (int c = 0; c < 3; c++) begin
         nextCyc;
         nCheck++; if (rrIf.in_ready !== 4'b0000 || rrIf.out_valid !== 1'b0 || rrIf.occupancy !== 2'd0)
            $display("FAIL in_reset_c%0d: ready %b valid %b occ %0d want 0000 0 0", c, rrIf.in_ready, rrIf.out_valid, rrIf.occupancy);
         else nPass++;
      end
      rst_n = 1'b1;
      #1;
      nCheck++; if (rrIf.in_ready !== 4'b0001) $display("FAIL first_grant_rr: got %b want 0001", rrIf.in_ready); else nPass++;
      nCheck++; if (fxIf.in_ready !== 4'b0001) $display("FAIL first_grant_fx: got %b want 0001", fxIf.in_ready); else nPass++;
   endtask

   task automatic test_round_robin;
      logic [1:0] expSrc;
      fxIf.in_valid = 4'b0000; fxIf.out_ready = 1'b1;
      rrIf.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         nextCyc;
         expSrc = 2'(k % 4);
         nCheck++; if (rrIf.out_valid !== 1'b1 || rrIf.out_src !== expSrc || rrIf.out_data !== (12'h100 + 12'(expSrc)))
            $display("FAIL rr_seq_%0d: valid %b src %0d data %h want 1 %0d %h", k, rrIf.out_valid, rrIf.out_src, rrIf.out_data, expSrc, 12'h100 + 12'(expSrc));
         else nPass++;
         nCheck++; if (rrIf.in_ready !== (4'b0001 << ((k + 1) % 4)))
            $display("FAIL rr_grant_%0d: got %b want %b", k, rrIf.in_ready, 4'b0001 << ((k + 1) % 4));
         else nPass++;
      end
   endtask

   task automatic test_fixed;
      fxIf.in_valid = 4'b1010; fxIf.in_data = dataSet(12'h100); fxIf.out_ready = 1'b1;
      #1;
      nCheck++; if (fxIf.in_ready !== 4'b0010) $display("FAIL fx_grant0: got %b want 0010", fxIf.in_ready); else nPass++;
      for (int k = 0; k < 5; k++) begin
         nextCyc;
         nCheck++; if (fxIf.out_src !== 2'd1 || fxIf.out_data !== 12'h101 || fxIf.in_ready !== 4'b0010 || fxIf.occupancy !== 2'd1)
            $display("FAIL fx_seq_%0d: src %0d data %h ready %b occ %0d want 1 101 0010 1", k, fxIf.out_src, fxIf.out_data, fxIf.in_ready, fxIf.occupancy);
         else nPass++;
      end
      fxIf.in_valid = 4'b0000;
   endtask

   task automatic test_backpressure;
      rrIf.in_valid = 4'b0000;
      nextCyc;
      nCheck++; if (rrIf.occupancy !== 2'd0) $display("FAIL bp_drained: got %0d want 0", rrIf.occupancy); else nPass++;
      rrIf.in_valid = 4'b0001; rrIf.in_data = {36'h0, 12'h5A0}; rrIf.out_ready = 1'b0;
      #1;
      nCheck++; if (rrIf.in_ready !== 4'b0001) $display("FAIL bp_grant0: got %b want 0001", rrIf.in_ready); else nPass++;
      nextCyc;
      rrIf.in_data = {36'h0, 12'h5A1};
      #1;
      nCheck++; if (rrIf.occupancy !== 2'd1 || rrIf.out_data !== 12'h5A0 || rrIf.in_ready !== 4'b0001)
         $display("FAIL bp_one: occ %0d data %h ready %b want 1 5a0 0001", rrIf.occupancy, rrIf.out_data, rrIf.in_ready);
      else nPass++;
      nextCyc;
      rrIf.in_data = {36'h0, 12'h5A2};
      #1;
      nCheck++; if (rrIf.occupancy !== 2'd2 || rrIf.out_data !== 12'h5A0 || rrIf.in_ready !== 4'b0000)
         $display("FAIL bp_full: occ %0d data %h ready %b want 2 5a0 0000", rrIf.occupancy, rrIf.out_data, rrIf.in_ready);
      else nPass++;
      nextCyc;
      nCheck++; if (rrIf.occupancy !== 2'd2 || rrIf.out_data !== 12'h5A0 || rrIf.out_src !== 2'd0 || rrIf.in_ready !== 4'b0000)
         $display("FAIL bp_hold: occ %0d data %h src %0d ready %b want 2 5a0 0 0000", rrIf.occupancy, rrIf.out_data, rrIf.out_src, rrIf.in_ready);
      else nPass++;
      rrIf.out_ready = 1'b1;
      #1;
      nCheck++; if (rrIf.in_ready !== 4'b0001) $display("FAIL bp_pop_space: got %b want 0001", rrIf.in_ready); else nPass++;
      nextCyc;
      rrIf.out_ready = 1'b0;
      #1;
      nCheck++; if (rrIf.occupancy !== 2'd2 || rrIf.out_data !== 12'h5A1)
         $display("FAIL bp_pop_push: occ %0d data %h want 2 5a1", rrIf.occupancy, rrIf.out_data);
      else nPass++;
   endtask

   task automatic test_sparse;
      rrIf.in_valid = 4'b0000; rrIf.out_ready = 1'b1;
      nextCyc;
      nextCyc;
      nCheck++; if (rrIf.occupancy !== 2'd0) $display("FAIL sp_drained: got %0d want 0", rrIf.occupancy); else nPass++;
      rrIf.in_valid = 4'b0110; rrIf.in_data = dataSet(12'h300);
      #1;
      nCheck++; if (rrIf.in_ready !== 4'b0010) $display("FAIL sp_setup_grant: got %b want 0010", rrIf.in_ready); else nPass++;
      nextCyc;
      rrIf.in_valid = 4'b0000;
      nextCyc;
      rrIf.in_valid = 4'b0010; rrIf.in_data = dataSet(12'h3C0);
      #1;
      nCheck++; if (rrIf.in_ready !== 4'b0010) $display("FAIL sp_single_grant: got %b want 0010", rrIf.in_ready); else nPass++;
      nextCyc;
      nCheck++; if (rrIf.out_valid !== 1'b1 || rrIf.out_src !== 2'd1 || rrIf.out_data !== 12'h3C1)
         $display("FAIL sp_output: valid %b src %0d data %h want 1 1 3c1", rrIf.out_valid, rrIf.out_src, rrIf.out_data);
      else nPass++;
      rrIf.in_valid = 4'b1111;
      #1;
      nCheck++; if (rrIf.in_ready !== 4'b0100) $display("FAIL sp_ptr_after: got %b want 0100", rrIf.in_ready); else nPass++;
      rrIf.in_valid = 4'b0000;
   endtask

   task automatic test_random;
      logic [15:0] m;
      logic [3:0]  want, badGot, badWant;
      logic [1:0]  lastIdx;
      logic [3:0]  run1 [32];
      int          cnt [4];
      int          seqErr, srcErr, badAt, repErr;
      seqErr = 0; srcErr = 0; badAt = -1; repErr = 0;
      badGot = '0; badWant = '0; lastIdx = '0;
      foreach (cnt[i]) cnt[i] = 0;
      rdIf.in_valid = 4'b1111; rdIf.in_data = dataSet(12'h100); rdIf.out_ready = 1'b1;
      rst_n = 1'b0;
      nextCyc;
      rst_n = 1'b1;
      m = 16'hACE1;
      for (int k = 0; k < 1000; k++) begin
         #1;
         want = 4'b0001 << m[1:0];
         if (rdIf.in_ready !== want) begin
            if (seqErr == 0) begin badAt = k; badGot = rdIf.in_ready; badWant = want; end
            seqErr++;
         end
         for (int i = 0; i < 4; i++) if (rdIf.in_ready[i] === 1'b1) cnt[i]++;
         if (k < 32) run1[k] = rdIf.in_ready;
         if (k > 0 && rdIf.out_src !== lastIdx) srcErr++;
         lastIdx = m[1:0];
         @(posedge clk);
         m = {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);
         @(negedge clk);
      end
      nCheck++; if (seqErr != 0) $display("FAIL rand_seq: %0d mismatches, first at %0d got %b want %b", seqErr, badAt, badGot, badWant); else nPass++;
      nCheck++; if (srcErr != 0) $display("FAIL rand_src: %0d out_src mismatches want 0", srcErr); else nPass++;
      for (int i = 0; i < 4; i++) begin
         nCheck++; if (cnt[i] < 190 || cnt[i] > 310) $display("FAIL rand_count_%0d: got %0d want 190..310", i, cnt[i]); else nPass++;
      end
      rst_n = 1'b0;
      nextCyc;
      rst_n = 1'b1;
      for (int k = 0; k < 32; k++) begin
         #1;
         if (rdIf.in_ready !== run1[k]) repErr++;
         nextCyc;
      end
      nCheck++; if (repErr != 0) $display("FAIL rand_repeat: %0d grants differ from first run want 0", repErr); else nPass++;
   endtask

   initial begin
      rst_n = 1'b1;
      rrIf.in_valid = '0; rrIf.in_data = '0; rrIf.out_ready = 1'b0;
      fxIf.in_valid = '0; fxIf.in_data = '0; fxIf.out_ready = 1'b0;
      rdIf.in_valid = '0; rdIf.in_data = '0; rdIf.out_ready = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_reset;
      test_round_robin;
      test_fixed;
      test_backpressure;
      test_sparse;
      test_random;
      $display("%0d/%0d checks passed", nPass, nCheck);
      $finish;
   end
endmodule
